state_dump_unit: RTL and testbench
==================================

Name: state_dump_unit

Overview:
Synthesizable debug readout block beside the 5-stage pipelined CPU. It counts run cycles, stalls and flushes. On request it streams a fixed frame of architectural state: counters, PC, x0..x31 and the low data-memory words. The frame goes out over a valid/ready word interface to a host-side dumper, which makes this block the on-chip responder to the off-chip state collector.

Parameters:
NUM_REGS, 32, register-file entries dumped (x0..x31)
NUM_MEM_WORDS, 8, data-memory words dumped from byte address 0x00 upward (0x00..0x1C)
CNT_W, 32, width of the cycle, stall and flush counters

Ports:
clk_i  in  1  clock, all logic on the rising edge
rst_i  in  1  reset, synchronous, active-low
start_i  in  1  CPU run enable; counters advance only while high
stall_i  in  1  pipeline stall indication, already qualified upstream to exclude branch-induced stalls
flush_i  in  1  pipeline flush indication
pc_i  in  32  current PC
dump_req_i  in  1  frame request pulse or level; sampled only in IDLE
reg_addr_o  out  5  register-file read address, combinational read port
reg_data_i  in  32  register-file read data, valid in the same cycle as reg_addr_o
mem_addr_o  out  32  data-memory byte address, word aligned, combinational read port
mem_data_i  in  32  data-memory read data, valid in the same cycle as mem_addr_o
dout_o  out  32  frame word
dout_valid_o  out  1  dout_o valid
dout_ready_i  in  1  sink accepts the word
dout_last_o  out  1  high with the final frame word
busy_o  out  1  frame in progress (state is not IDLE)

Behaviour:
- Reset (rst_i==0 at a rising edge): state=IDLE, idx=0, all counters=0, snapshot registers=0, dout_o=0, dout_valid_o=0, dout_last_o=0, busy_o=0. Reset mid-frame aborts at once; there is no partial-frame completion.
- Counters, every edge with start_i==1:
  - cycle_cnt += 1.
  - stall_cnt += stall_i.
  - flush_cnt += flush_i.
  - stall and flush in the same cycle both increment.
  - Each counter wraps from 2^CNT_W-1 to 0.
  - Counting continues during a frame.
- Frame order, idx 0..(3+NUM_REGS+NUM_MEM_WORDS), 44 words at defaults:
  - idx0 = cycle snapshot, idx1 = stall snapshot, idx2 = flush snapshot, idx3 = PC snapshot.
  - idx4..35 = x[idx-4].
  - idx36..43 = mem at byte address 4*(idx-36).
- Snapshot: in the IDLE-accept cycle, cycle/stall/flush/PC are captured. These values are the pre-increment counter values from that cycle. Registers and memory are read live at LOAD time.
- Address outputs are combinational from idx:
  - reg_addr_o = idx-4 when 4<=idx<=35, else 0.
  - mem_addr_o = (idx-36)<<2 when 36<=idx<=43, else 0.
- FSM:
  - IDLE: if dump_req_i==1, capture snapshot, set idx=0, go to LOAD. Otherwise stay.
  - LOAD: dout_o <= word(idx); dout_last_o <= (idx==last); dout_valid_o <= 1; go to SEND.
  - SEND: hold dout_o, dout_valid_o and dout_last_o stable while dout_ready_i==0. On dout_ready_i==1: clear dout_valid_o and dout_last_o. If last, go to IDLE; else idx += 1 and go to LOAD.
- Latency and throughput:
  - First dout_valid_o is high 2 edges after dump_req_i is sampled in IDLE.
  - Each word takes a LOAD bubble, so maximum throughput is 1 word per 2 cycles.
  - A full frame with ready tied high takes 89 cycles from request to return to IDLE.
- dump_req_i while busy_o==1 is ignored and not queued. A request held high across return to IDLE starts a new frame on the following edge.
- dout_ready_i is ignored outside SEND.
- Register x0 is dumped as whatever reg_data_i returns; no forcing to 0 inside this block.

Test Plan:
1. Reset then idle: rst_i low for 2 cycles, then high with start_i=0 for 5 cycles -> all outputs 0, counters stay 0, busy_o=0.
2. Counting: start_i=1 for 64 cycles with stall_i high for 3 cycles, flush_i high for 2 cycles, and one cycle with both high -> dump frame words 0..2 = 64, 4, 3.
3. Full frame, ready tied 1: register model x5=7, mem[0]=5, pc_i=0x40 at request -> 44 words in order. Word3=0x40, word9=7, word36=5, dout_last_o only on word 43, return to IDLE 89 cycles after request.
4. Backpressure: dout_ready_i random 30% high -> dout_o, dout_valid_o and dout_last_o unchanged while stalled; no word lost or duplicated, compared against the scoreboard.
5. Busy request and reset abort: pulse dump_req_i at word 10 -> ignored, single frame only. Then assert rst_i low at word 20 -> next edge dout_valid_o=0, busy_o=0, counters 0.
6. Counter wrap: CNT_W=4, start_i=1 for 17 cycles -> cycle snapshot = 1.

Source files
------------

// File: rtl/state_dump_unit.sv
// Debug readout block: counts run cycles, stalls and flushes, and on request
// streams a fixed frame {cycle, stall, flush, PC, x0..xN, mem words} over a
// valid/ready word interface to the host-side state collector.
module state_dump_unit #(
  parameter int NUM_REGS      = 32,
  parameter int NUM_MEM_WORDS = 8,
  parameter int CNT_W         = 32
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic        stall_i,
  input  logic        flush_i,
  input  logic [31:0] pc_i,
  input  logic        dump_req_i,
  output logic [4:0]  reg_addr_o,
  input  logic [31:0] reg_data_i,
  output logic [31:0] mem_addr_o,
  input  logic [31:0] mem_data_i,
  output logic [31:0] dout_o,
  output logic        dout_valid_o,
  input  logic        dout_ready_i,
  output logic        dout_last_o,
  output logic        busy_o
);
  localparam int          FRAME_LEN = 4 + NUM_REGS + NUM_MEM_WORDS;
  localparam int          IDX_W     = $clog2(FRAME_LEN);
  localparam logic [31:0] REG_BASE  = 32'd4;
  localparam logic [31:0] MEM_BASE  = 32'(4 + NUM_REGS);
  localparam logic [31:0] LAST_IDX  = 32'(FRAME_LEN - 1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SEND} state_e;

  typedef struct packed {
    logic [CNT_W-1:0] cyc;
    logic [CNT_W-1:0] stall;
    logic [CNT_W-1:0] flush;
    logic [31:0]      pc;
  } snap_t;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] cyc_cnt_q, cyc_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  snap_t            snap_q, snap_d;
  logic [31:0]      dout_q, dout_d;
  logic             valid_q, valid_d;
  logic             last_q, last_d;
  logic [31:0]      idx_w;
  logic [31:0]      word;

  assign idx_w        = 32'(idx_q);
  assign dout_o       = dout_q;
  assign dout_valid_o = valid_q;
  assign dout_last_o  = last_q;
  assign busy_o       = (state_q != S_IDLE);

  // Free-running event counters; they keep counting while a frame is out.
  always_comb begin
    cyc_cnt_d   = cyc_cnt_q;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (start_i) begin
      cyc_cnt_d   = cyc_cnt_q + CNT_W'(1);
      stall_cnt_d = stall_cnt_q + CNT_W'(stall_i);
      flush_cnt_d = flush_cnt_q + CNT_W'(flush_i);
    end
  end

  // Read addresses follow idx directly so the arrays answer in the LOAD cycle.
  always_comb begin
    reg_addr_o = '0;
    mem_addr_o = '0;
    if (idx_w >= REG_BASE && idx_w < MEM_BASE) reg_addr_o = 5'(idx_w - REG_BASE);
    if (idx_w >= MEM_BASE && idx_w <= LAST_IDX) mem_addr_o = (idx_w - MEM_BASE) << 2;
  end

  // Frame word selected by idx: snapshot header, then live register/memory reads.
  always_comb begin
    word = (idx_w < MEM_BASE) ? reg_data_i : mem_data_i;
    if (idx_w == 32'd0)      word = 32'(snap_q.cyc);
    else if (idx_w == 32'd1) word = 32'(snap_q.stall);
    else if (idx_w == 32'd2) word = 32'(snap_q.flush);
    else if (idx_w == 32'd3) word = snap_q.pc;
  end

  // Frame FSM: IDLE accepts a request, LOAD registers a word, SEND waits for ready.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    snap_d  = snap_q;
    dout_d  = dout_q;
    valid_d = valid_q;
    last_d  = last_q;
    unique case (state_q)
      S_IDLE: begin
        if (dump_req_i) begin
          // Pre-increment values: what the counters held in the accept cycle.
          snap_d  = '{cyc: cyc_cnt_q, stall: stall_cnt_q, flush: flush_cnt_q, pc: pc_i};
          idx_d   = '0;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        dout_d  = word;
        last_d  = (idx_w == LAST_IDX);
        valid_d = 1'b1;
        state_d = S_SEND;
      end
      S_SEND: begin
        if (dout_ready_i) begin
          valid_d = 1'b0;
          last_d  = 1'b0;
          if (last_q) begin
            idx_d   = '0;
            state_d = S_IDLE;
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            state_d = S_LOAD;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and counter registers; reset aborts any frame in flight.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      cyc_cnt_q   <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
      snap_q      <= '0;
      dout_q      <= '0;
      valid_q     <= 1'b0;
      last_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cyc_cnt_q   <= cyc_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
      snap_q      <= snap_d;
      dout_q      <= dout_d;
      valid_q     <= valid_d;
      last_q      <= last_d;
    end
  end

endmodule

// File: tb/tb_state_dump_unit.sv
// Bench for state_dump_unit: random traffic against a frame-level model
// (event totals plus the expected word list built at request time).
module tb_state_dump_unit;
  localparam int NR = 32, NM = 8, FL = 4 + NR + NM;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_i, start_i, stall_i, flush_i, dump_req_i, dout_ready_i;
  logic [31:0] pc_i, reg_data_i, mem_data_i, dout_o, mem_addr_o;
  logic [4:0]  reg_addr_o;
  logic        dout_valid_o, dout_last_o, busy_o;

  // Narrow-counter instance for the wrap check.
  logic        w_start, w_req, w_ready, w_zero;
  logic [31:0] w_pc, w_data, w_dout, w_mem_addr;
  logic [4:0]  w_reg_addr;
  logic        w_valid, w_last, w_busy;

  logic [31:0] regs [NR];
  logic [31:0] mem  [NM];
  logic [31:0] got_w [FL];
  logic [31:0] m_cyc, m_stall, m_flush;
  int checks = 0, errors = 0;

  assign reg_data_i = regs[reg_addr_o];
  assign mem_data_i = mem[mem_addr_o[4:2]];
  assign w_zero = 1'b0;
  assign w_pc   = 32'h0;
  assign w_data = 32'h0;
  assign w_ready = 1'b1;

  state_dump_unit dut (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .stall_i(stall_i),
    .flush_i(flush_i), .pc_i(pc_i), .dump_req_i(dump_req_i),
    .reg_addr_o(reg_addr_o), .reg_data_i(reg_data_i),
    .mem_addr_o(mem_addr_o), .mem_data_i(mem_data_i),
    .dout_o(dout_o), .dout_valid_o(dout_valid_o), .dout_ready_i(dout_ready_i),
    .dout_last_o(dout_last_o), .busy_o(busy_o)
  );

  state_dump_unit #(.CNT_W(4)) dut_w (
    .clk_i(clk), .rst_i(rst_i), .start_i(w_start), .stall_i(w_zero),
    .flush_i(w_zero), .pc_i(w_pc), .dump_req_i(w_req),
    .reg_addr_o(w_reg_addr), .reg_data_i(w_data),
    .mem_addr_o(w_mem_addr), .mem_data_i(w_data),
    .dout_o(w_dout), .dout_valid_o(w_valid), .dout_ready_i(w_ready),
    .dout_last_o(w_last), .busy_o(w_busy)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // Advance one clock; the model applies the counting rules to the inputs
  // present at this edge, then outputs are sampled 1 ns after it.
  task automatic step();
    if (!rst_i) begin
      m_cyc = 0; m_stall = 0; m_flush = 0;
    end else if (start_i) begin
      m_cyc   = m_cyc + 1;
      m_stall = m_stall + 32'(stall_i);
      m_flush = m_flush + 32'(flush_i);
    end
    @(posedge clk);
    #1;
  endtask

  // Request one frame and consume it. pulse_at: word count at which to raise a
  // request while busy (-1 none); abort_at: word count at which to reset (-1 none).
  task automatic run_frame(input int rdy_pct, input int pulse_at, input int abort_at,
                           input bit chk_lat);
    logic [31:0] exp [$];
    logic [31:0] pd;
    logic        pv, pl;
    int          got_n, cyc;
    exp = {};
    exp.push_back(m_cyc); exp.push_back(m_stall);
    exp.push_back(m_flush); exp.push_back(pc_i);
    for (int i = 0; i < NR; i++) exp.push_back(regs[i]);
    for (int i = 0; i < NM; i++) exp.push_back(mem[i]);
    dump_req_i = 1'b1;
    step();
    dump_req_i = 1'b0;
    cyc = 1;
    got_n = 0;
    if (chk_lat) chk("valid_in_load", 32'(dout_valid_o), 0);
    while (busy_o && cyc < 3000) begin
      if (abort_at >= 0 && got_n == abort_at) begin
        rst_i = 1'b0; start_i = 1'b0; stall_i = 1'b0; flush_i = 1'b0;
        step();
        chk("abort_valid", 32'(dout_valid_o), 0);
        chk("abort_busy", 32'(busy_o), 0);
        chk("abort_last", 32'(dout_last_o), 0);
        chk("abort_dout", dout_o, 0);
        rst_i = 1'b1;
        return;
      end
      dout_ready_i = ($urandom_range(99) < 32'(rdy_pct));
      dump_req_i   = (got_n == pulse_at);
      start_i = 1'($urandom); stall_i = 1'($urandom); flush_i = 1'($urandom);
      pc_i    = $urandom;
      pv = dout_valid_o; pd = dout_o; pl = dout_last_o;
      step();
      cyc++;
      if (chk_lat && cyc == 2) chk("first_valid_latency", 32'(dout_valid_o), 1);
      if (pv && dout_ready_i) begin
        if (got_n < FL) begin
          chk($sformatf("word%0d", got_n), pd, exp[got_n]);
          chk($sformatf("last%0d", got_n), 32'(pl), 32'(got_n == FL - 1));
          got_w[got_n] = pd;
        end
        got_n++;
      end else if (pv) begin
        chk("hold_dout", dout_o, pd);
        chk("hold_valid", 32'(dout_valid_o), 1);
        chk("hold_last", 32'(dout_last_o), 32'(pl));
      end
    end
    dump_req_i = 1'b0;
    start_i = 1'b0; stall_i = 1'b0; flush_i = 1'b0;
    chk("frame_done_busy", 32'(busy_o), 0);
    chk("frame_word_count", 32'(got_n), 32'(FL));
    if (chk_lat) chk("frame_cycles", 32'(cyc), 89);
  endtask

  initial begin
    rst_i = 1'b0; start_i = 1'b0; stall_i = 1'b0; flush_i = 1'b0;
    dump_req_i = 1'b0; dout_ready_i = 1'b0; pc_i = 32'h0;
    w_start = 1'b0; w_req = 1'b0;
    m_cyc = 0; m_stall = 0; m_flush = 0;
    for (int i = 0; i < NR; i++) regs[i] = $urandom;
    for (int i = 0; i < NM; i++) mem[i] = $urandom;

    // 1. reset then idle
    step(); step();
    rst_i = 1'b1;
    for (int i = 0; i < 5; i++) step();
    chk("idle_dout", dout_o, 0);
    chk("idle_valid", 32'(dout_valid_o), 0);
    chk("idle_last", 32'(dout_last_o), 0);
    chk("idle_busy", 32'(busy_o), 0);
    chk("idle_reg_addr", 32'(reg_addr_o), 0);
    chk("idle_mem_addr", mem_addr_o, 0);

    // 2. counting: stalls on cycles 0-2, flushes on 5-6, both on 10
    for (int i = 0; i < 64; i++) begin
      start_i = 1'b1;
      stall_i = (i < 3) || (i == 10);
      flush_i = (i == 5) || (i == 6) || (i == 10);
      step();
    end
    start_i = 1'b0; stall_i = 1'b0; flush_i = 1'b0;
    run_frame(100, -1, -1, 0);
    chk("cnt_cycle", got_w[0], 64);
    chk("cnt_stall", got_w[1], 4);
    chk("cnt_flush", got_w[2], 3);

    // 3. full frame, ready high, fixed probe values
    regs[5] = 32'd7; mem[0] = 32'd5; pc_i = 32'h40;
    run_frame(100, -1, -1, 1);
    chk("word3_pc", got_w[3], 32'h40);
    chk("word9_x5", got_w[9], 7);
    chk("word36_mem0", got_w[36], 5);

    // 4. backpressure with random data
    for (int f = 0; f < 2; f++) begin
      for (int i = 0; i < NR; i++) regs[i] = $urandom;
      for (int i = 0; i < NM; i++) mem[i] = $urandom;
      pc_i = $urandom;
      run_frame(30, -1, -1, 0);
    end

    // 5. request while busy is dropped; then reset mid-frame
    run_frame(70, 10, -1, 0);
    for (int i = 0; i < 4; i++) step();
    chk("no_requeue_busy", 32'(busy_o), 0);
    chk("no_requeue_valid", 32'(dout_valid_o), 0);
    run_frame(100, -1, 20, 0);
    step();
    run_frame(60, -1, -1, 0);
    chk("post_reset_cycle", got_w[0], m_cyc - m_cyc);
    chk("post_reset_stall", got_w[1], 0);

    // 6. 4-bit counter wraps after 16 cycles
    w_start = 1'b1;
    for (int i = 0; i < 17; i++) step();
    w_start = 1'b0;
    w_req = 1'b1;
    step();
    w_req = 1'b0;
    step();
    chk("wrap_valid", 32'(w_valid), 1);
    chk("wrap_cycle", w_dout, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
